// File: rtl/pipe_adder_pkg.sv
// Shared constants for the segmented pipelined adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_adder_pkg;

  // Default operand width and bits added per pipeline stage.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

endpackage

// File: rtl/pipe_adder_seg.sv
// One adder stage: SEG_W-bit add with carry in/out, registered with its valid bit.
// Latency: 1 cycle when en=1.
// Backpressure: en=0 freezes sum, carry and valid.
//
// Ports: clk, rstn (async active-low), en (advance), vld_in/vld (slot valid),
//        a/b/ci (segment operands, carry in), s/co (registered sum, carry out).
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             vld_in,
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic             vld,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  logic [SEG_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, ci};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= 1'b0;
      s   <= '0;
      co  <= 1'b0;
    end else if (en) begin
      vld <= vld_in;
      s   <= sum[SEG_W-1:0];
      co  <= sum[SEG_W];
    end
  end

endmodule

// File: rtl/pipe_adder_param.sv
// Pipelined add/subtract, SEG_W bits per stage with carry rippling stage to stage.
// Latency: STAGES = WIDTH/SEG_W cycles, one result per cycle.
// Backpressure: whole pipe holds when out_valid && !out_ready; in_ready = !out_valid | out_ready.
//
// Ports: clk, rstn (async active-low); in_valid/in_ready + a, b, ci, sub (operands);
//        out_valid/out_ready + s, co, ov (result, carry / no-borrow, signed overflow).
module pipe_adder_param
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int STAGES = WIDTH / SEG_W;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Single advance enable: every stage moves together or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction folds into addition: a + ~b + ~ci == a - b - ci.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~ci : ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    localparam int HI = LO + SEG_W;

    // op_a/op_b: operand bits not yet added (this segment plus everything above).
    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                carry_in;
    logic                vld_in;
    logic                vld;
    logic [SEG_W-1:0]    seg_s;
    logic                seg_co;
    // sum_w: all sum bits produced so far, aligned with this stage's output.
    logic [HI-1:0]       sum_w;

    if (k == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = b_eff;
      assign carry_in = c_eff;
      assign vld_in   = in_valid;
    end else begin : g_body
      assign op_a     = g_stg[k-1].g_up.a_up;
      assign op_b     = g_stg[k-1].g_up.b_up;
      assign carry_in = g_stg[k-1].seg_co;
      assign vld_in   = g_stg[k-1].vld;
    end

    pipe_adder_seg #(.SEG_W(SEG_W)) u_seg (
      .clk    (clk),
      .rstn   (rstn),
      .en     (adv),
      .vld_in (vld_in),
      .a      (op_a[SEG_W-1:0]),
      .b      (op_b[SEG_W-1:0]),
      .ci     (carry_in),
      .vld    (vld),
      .s      (seg_s),
      .co     (seg_co)
    );

    // Deskew: lower sum segments ride alongside so the word completes at the last stage.
    if (k == 0) begin : g_s0
      assign sum_w = seg_s;
    end else begin : g_lo
      logic [LO-1:0] lo_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          lo_q <= '0;
        end else if (adv) begin
          lo_q <= g_stg[k-1].sum_w;
        end
      end
      assign sum_w = {seg_s, lo_q};
    end

    // Skew: upper operand segments wait here until their stage comes up.
    if (k < STAGES - 1) begin : g_up
      logic [WIDTH-HI-1:0] a_up;
      logic [WIDTH-HI-1:0] b_up;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_up <= '0;
          b_up <= '0;
        end else if (adv) begin
          a_up <= op_a[WIDTH-LO-1:SEG_W];
          b_up <= op_b[WIDTH-LO-1:SEG_W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      // Operand MSBs captured with the last segment so ov derives from registers only.
      logic a_msb_q;
      logic b_msb_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (adv) begin
          a_msb_q <= op_a[WIDTH-LO-1];
          b_msb_q <= op_b[WIDTH-LO-1];
        end
      end
      assign out_valid = vld;
      assign s         = sum_w;
      assign co        = seg_co;
      // Same-sign operands producing a different-sign result; all-zero under reset.
      assign ov        = (a_msb_q == b_msb_q) && (sum_w[HI-1] != a_msb_q);
    end
  end

endmodule

// File: tb/tb_pipe_adder_param.sv
module tb_pipe_adder_param;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         co;
  logic         ov;

  always #5 clk = ~clk;

  pipe_adder_param #(.WIDTH(W), .SEG_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          n_out = 0;
  logic [17:0] exp_q[$];
  logic        held = 1'b0;
  logic [17:0] held_v;

  // Reference: integer arithmetic, result packed as {s, co, ov}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mci, input logic msub);
    int   u;
    int   sv;
    logic rco;
    logic rov;
    if (!msub) begin
      u   = int'(ma) + int'(mb) + int'(mci);
      sv  = int'($signed(ma)) + int'($signed(mb)) + int'(mci);
      rco = (u > 65535);
    end else begin
      u   = int'(ma) - int'(mb) - int'(mci);
      sv  = int'($signed(ma)) - int'($signed(mb)) - int'(mci);
      rco = (u >= 0);
    end
    rov = (sv > 32767) || (sv < -32768);
    return {u[15:0], rco, rov};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                       input logic vci, input logic vsub, input logic vvld);
    a = va; b = vb; ci = vci; sub = vsub; in_valid = vvld;
  endtask

  // Compare process: inputs and outputs are stable at the negedge for the coming posedge.
  always @(negedge clk) begin
    if (rstn) begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (held) begin
        check("stall out_valid", out_valid, 1'b1);
        check("stall data", {s, co, ov}, held_v);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious out_valid", out_valid, 1'b0);
        else check("result", {s, co, ov}, exp_q.pop_front());
        n_out++;
      end
      held   = out_valid && !out_ready;
      held_v = {s, co, ov};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
    end else begin
      held = 1'b0;
    end
  end

  // Single vector on an idle pipe; result and latency against literals.
  task automatic run_one(input string name, input logic [15:0] va, input logic [15:0] vb,
                         input logic vci, input logic vsub,
                         input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    out_ready = 1'b1;
    drive(va, vb, vci, vsub, 1'b1);
    step();
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, lat, 4);
    check({name, " s"}, s, es);
    check({name, " co"}, co, eco);
    check({name, " ov"}, ov, eov);
    step();
  endtask

  logic [33:0] svec [8];
  int          idx;
  int          base;
  int          acc;
  int          cyc;
  logic        take;

  initial begin
    // Reset state.
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset s", s, 16'h0000);
    check("reset co", co, 1'b0);
    check("reset ov", ov, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    step();
    step();
    rstn = 1'b1;
    step();

    // Pin the reference model to hand-computed values.
    check("model ripple", model(16'hFFFF, 16'h0001, 1'b0, 1'b0), {16'h0000, 1'b1, 1'b0});
    check("model sub", model(16'h0005, 16'h0007, 1'b0, 1'b1), {16'hFFFE, 1'b0, 1'b0});
    check("model ovf", model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {16'h8000, 1'b0, 1'b1});
    check("model sub ovf", model(16'h8000, 16'h0001, 1'b0, 1'b1), {16'h7FFF, 1'b1, 1'b1});

    // Directed vectors.
    run_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run_one("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("add ci", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Stream of 8 with a 3-cycle output stall in the middle.
    svec[0] = {16'h1234, 16'h4321, 1'b0, 1'b0};
    svec[1] = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    svec[2] = {16'h8000, 16'h8000, 1'b0, 1'b0};
    svec[3] = {16'h0000, 16'h0001, 1'b0, 1'b1};
    svec[4] = {16'h7FFF, 16'hFFFF, 1'b0, 1'b1};
    svec[5] = {16'hABCD, 16'h1234, 1'b1, 1'b1};
    svec[6] = {16'h0FFF, 16'h0001, 1'b0, 1'b0};
    svec[7] = {16'h5555, 16'hAAAA, 1'b1, 1'b0};
    idx  = 0;
    base = n_out;
    cyc  = 0;
    while ((idx < 8 || n_out < base + 8) && cyc < 60) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) drive(svec[idx][33:18], svec[idx][17:2], svec[idx][1], svec[idx][0], 1'b1);
      else in_valid = 1'b0;
      #1;
      if (cyc >= 5 && cyc <= 7) check("stall in_ready", in_ready, 1'b0);
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take) idx++;
      cyc++;
    end
    check("stream accepted", idx, 8);
    check("stream results", n_out - base, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();

    // Reset mid-stream with a result held at the output.
    for (int i = 0; i < 5; i++) begin
      drive(16'(i * 16'h1111), 16'h0101, 1'b0, 1'b0, 1'b1);
      step();
    end
    out_ready = 1'b0;
    drive(16'h2222, 16'h3333, 1'b0, 1'b0, 1'b1);
    step();
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("mid reset out_valid", out_valid, 1'b0);
    check("mid reset s", s, 16'h0000);
    check("mid reset co", co, 1'b0);
    check("mid reset ov", ov, 1'b0);
    check("mid reset in_ready", in_ready, 1'b1);
    step();
    step();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    rstn = 1'b1;
    run_one("post reset", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Random traffic with random valid/ready.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("random accepted", acc, 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("drain empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_adder_param.md
PIPE_ADDER_PARAM -- requirements
Module: pipe_adder_param

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width; SHALL be a positive multiple of SEG_W.
REQ-002 Parameter SEG_W, default 4: bits added per pipeline stage; STAGES = WIDTH/SEG_W, derived and not overridable.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in, or borrow-in when sub=1.
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 s  output  WIDTH  sum or difference.
REQ-014 co  output  1  carry out of the MSB, i.e. unsigned no-borrow when sub=1.
REQ-015 ov  output  1  two's-complement signed overflow.

Function
REQ-016 Operation: sub=0 gives {co,s} = a + b + ci; sub=1 gives {co,s} = a + ~b + (~ci & 1), i.e. a - b - ci.
REQ-017 ov SHALL be 1 when a and the effective B (b, or ~b when sub=1) share an MSB and s's MSB differs from it.
REQ-018 Stage k (0..STAGES-1) adds segment k of the operands plus the carry registered from stage k-1.
  - Stage 0 adds the effective carry-in.
  - Upper segments not yet added are skew-delayed.
  - Lower sum segments already produced are delayed to align.
REQ-019 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid with no stall; throughput SHALL be one result per cycle.
REQ-020 Accept: an input is accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-021 Advance: adv = !out_valid | out_ready; in_ready = adv, combinational.
REQ-022 When adv=0 all stage registers, including per-stage valid bits, SHALL hold.
REQ-023 Output handshake: a result leaves on a rising edge when out_valid=1 and out_ready=1.
  - s, co and ov SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Bubbles: in_valid=0 on an advance SHALL insert an invalid slot.
  - Bubbles SHALL propagate without changing outputs or valid flags of other slots.
REQ-025 Results SHALL leave in acceptance order; none dropped or duplicated across any stall pattern.
REQ-026 Simultaneous accept and emit in the same cycle SHALL be supported at full rate.
REQ-027 a, b, ci and sub SHALL be ignored when not accepted.
REQ-028 WIDTH=SEG_W (STAGES=1) SHALL yield a single registered adder with latency 1.

Reset
REQ-029 rstn low SHALL immediately clear all stage valid bits; out_valid=0, s=0, co=0, ov=0.
REQ-030 While rstn is low, in_ready SHALL be 1 (out_valid=0).
REQ-031 No input is accepted on any edge where rstn is low.
REQ-032 Reset mid-operation SHALL discard all in-flight results; the first result after release comes from the first post-reset accepted input.

Structure
REQ-033 Package pipe_adder_pkg SHALL hold the default WIDTH and SEG_W constants.
REQ-034 One sub-module, pipe_adder_seg, SHALL implement one stage: SEG_W-bit add with carry in/out, registered under a hold enable, with its valid bit.
  - The top SHALL generate-instantiate STAGES copies plus the skew/deskew registers.

Verification (WIDTH=16, SEG_W=4)
REQ-035 Reset: assert rstn=0 mid-stream -> out_valid=0, s=0, co=0, ov=0 at once; no stale result after release.
REQ-036 Carry ripple: a=16'hFFFF, b=16'h0001, ci=0, sub=0 -> after 4 cycles s=16'h0000, co=1, ov=0.
REQ-037 Subtract: a=16'h0005, b=16'h0007, sub=1, ci=0 -> s=16'hFFFE, co=0, ov=0.
  - Then with ci=1 -> s=16'hFFFD.
REQ-038 Overflow: a=16'h7FFF, b=16'h0001, sub=0, ci=0 -> s=16'h8000, co=0, ov=1.
REQ-039 Stream: 8 back-to-back vectors with out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 during the stall.
  - All 8 results in order, matching the golden model.
  - Outputs stable while stalled.
REQ-040 Random: 10k random a/b/ci/sub with random in_valid/out_ready -> every result equals the reference model.
